fir_ntap_stream: RTL and testbench

//  Parametrised N-tap FIR filter; successor to the fixed 3-tap filter.

---
 rtl/fir_ntap_stream.sv | 130 +++++++++++++
 tb/tb_fir_ntap_stream.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/fir_ntap_stream.sv
// Streaming N-tap FIR filter with unsigned arithmetic, loadable coefficients,
// and output scaling with round-half-up and saturation.
// Samples pass through three register stages: the delay line captures the
// sample, the products stage multiplies every tap by its coefficient, and the
// output stage sums, scales, saturates and registers y/sat/out_valid.
// Coefficients reset to 1, so out of reset the filter is a TAPS-point moving sum.
module fir_ntap_stream #(
    parameter int DATA_W    = 8,
    parameter int COEF_W    = 8,
    parameter int TAPS      = 8,
    parameter int ACC_W     = DATA_W + COEF_W + $clog2(TAPS),
    parameter int OUT_SHIFT = 0,
    parameter int OUT_W     = ACC_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        xin,
    input  logic                     coef_we,
    input  logic [$clog2(TAPS)-1:0]  coef_addr,
    input  logic [COEF_W-1:0]        coef_data,
    output logic                     out_valid,
    output logic [OUT_W-1:0]         y,
    output logic                     sat
);

    localparam int PROD_W = DATA_W + COEF_W;
    // One spare bit so the rounding constant can never wrap the accumulator.
    localparam int RND_W  = ACC_W + 1;
    // Comparison width large enough for both the rounded value and the output max.
    localparam int CMP_W  = (OUT_W > RND_W) ? OUT_W : RND_W;

    logic [DATA_W-1:0] x_q [TAPS];
    logic [COEF_W-1:0] c_q [TAPS];
    logic [PROD_W-1:0] p_q [TAPS];
    logic              v0_q;
    logic              v1_q;

    logic [ACC_W-1:0]  acc;
    logic [RND_W-1:0]  rnd;
    logic [OUT_W-1:0]  y_nxt;
    logic              sat_nxt;

    // Delay line: shifts only on an accepted sample; clear empties it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < TAPS; k++) x_q[k] <= '0;
        end else if (clear) begin
            for (int k = 0; k < TAPS; k++) x_q[k] <= '0;
        end else if (in_valid) begin
            x_q[0] <= xin;
            for (int k = 1; k < TAPS; k++) x_q[k] <= x_q[k-1];
        end
    end

    // Coefficient bank: writes are independent of clear and of the stream;
    // addresses beyond the last tap are dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < TAPS; k++) c_q[k] <= COEF_W'(1);
        end else if (coef_we && (int'(coef_addr) < TAPS)) begin
            c_q[coef_addr] <= coef_data;
        end
    end

    // Products stage plus the two valid stages that track it; products are
    // only refreshed when a newly accepted sample sits in the delay line.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v0_q <= 1'b0;
            v1_q <= 1'b0;
            for (int k = 0; k < TAPS; k++) p_q[k] <= '0;
        end else if (clear) begin
            v0_q <= 1'b0;
            v1_q <= 1'b0;
            for (int k = 0; k < TAPS; k++) p_q[k] <= '0;
        end else begin
            v0_q <= in_valid;
            v1_q <= v0_q;
            if (v0_q) begin
                for (int k = 0; k < TAPS; k++)
                    p_q[k] <= PROD_W'(x_q[k]) * PROD_W'(c_q[k]);
            end
        end
    end

    // Full-precision sum of all registered products.
    always_comb begin
        acc = '0;
        for (int k = 0; k < TAPS; k++) acc = acc + ACC_W'(p_q[k]);
    end

    // Scale with round-half-up, or pass the sum straight through.
    if (OUT_SHIFT > 0) begin : g_round
        localparam logic [RND_W-1:0] HALF = RND_W'(1) << (OUT_SHIFT - 1);
        assign rnd = (RND_W'(acc) + HALF) >> OUT_SHIFT;
    end else begin : g_noround
        assign rnd = RND_W'(acc);
    end

    // Clip to the output range and flag the clip.
    always_comb begin
        sat_nxt = 1'b0;
        y_nxt   = '0;
        if (CMP_W'(rnd) > CMP_W'({OUT_W{1'b1}})) begin
            sat_nxt = 1'b1;
            y_nxt   = '1;
        end else begin
            y_nxt   = OUT_W'(rnd);
        end
    end

    // Output stage: y and sat only move with out_valid; clear suppresses the
    // sample that would otherwise emerge on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            y         <= '0;
            sat       <= 1'b0;
        end else begin
            out_valid <= v1_q & ~clear;
            if (v1_q && !clear) begin
                y   <= y_nxt;
                sat <= sat_nxt;
            end
        end
    end

endmodule

// File: tb/tb_fir_ntap_stream.sv
// Bench for fir_ntap_stream: one stimulus stream drives three instances
// (full width, 12-bit saturating, 12-bit with shift 8). A reference model
// keeps the accepted-sample history and coefficients and queues the expected
// accumulator sum; a monitor pops and checks whenever out_valid is seen.
module tb_fir_ntap_stream;

    localparam int TAPS = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  xin = '0;
    logic        coef_we = 1'b0;
    logic [2:0]  coef_addr = '0;
    logic [7:0]  coef_data = '0;

    logic        ov0, ov1, ov2;
    logic [18:0] y0;
    logic [11:0] y1, y2;
    logic        s0, s1, s2;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    fir_ntap_stream dut_full (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .xin(xin),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .out_valid(ov0), .y(y0), .sat(s0)
    );

    fir_ntap_stream #(.OUT_W(12)) dut_sat (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .xin(xin),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .out_valid(ov1), .y(y1), .sat(s1)
    );

    fir_ntap_stream #(.OUT_W(12), .OUT_SHIFT(8)) dut_rnd (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .xin(xin),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .out_valid(ov2), .y(y2), .sat(s2)
    );

    typedef struct {
        longint acc;
        int     due;
    } exp_t;

    exp_t   sbq[$];
    longint smp[$];
    longint coef_m[TAPS];
    longint last_y[3];
    longint last_s[3];
    exp_t   mon_e;

    function automatic void chk(string name, longint act, longint expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, expv, cyc);
        end
    endfunction

    function automatic longint scaled(longint acc, int sh);
        if (sh > 0) return (acc + (longint'(1) << (sh - 1))) >> sh;
        return acc;
    endfunction

    function automatic void check_inst(int idx, string nm, longint yv, longint sv,
                                       longint acc, int sh, int w);
        longint r, mx, ey, es;
        r  = scaled(acc, sh);
        mx = (longint'(1) << w) - 1;
        ey = (r > mx) ? mx : r;
        es = (r > mx) ? 1 : 0;
        chk({nm, "_y"}, yv, ey);
        chk({nm, "_sat"}, sv, es);
        last_y[idx] = ey;
        last_s[idx] = es;
    endfunction

    function automatic void hold_inst(int idx, string nm, longint yv, longint sv);
        chk({nm, "_hold_y"}, yv, last_y[idx]);
        chk({nm, "_hold_sat"}, sv, last_s[idx]);
    endfunction

    // Reference model: acts on each rising edge using the inputs driven before it.
    always @(posedge clk or negedge rst) begin
        longint acc;
        if (!rst) begin
            sbq.delete();
            smp.delete();
            for (int k = 0; k < TAPS; k++) coef_m[k] = 1;
        end else begin
            cyc++;
            if (coef_we) coef_m[coef_addr] = coef_data;
            if (clear) begin
                smp.delete();
                sbq.delete();
            end else if (in_valid) begin
                smp.push_front(longint'(xin));
                if (smp.size() > TAPS) void'(smp.pop_back());
                acc = 0;
                for (int k = 0; k < smp.size(); k++) acc += smp[k] * coef_m[k];
                sbq.push_back('{acc: acc, due: cyc + 2});
            end
        end
    end

    // Monitor: checks outputs on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                last_y[i] = 0;
                last_s[i] = 0;
            end
        end else begin
            chk("valid_agree_sat", ov1, ov0);
            chk("valid_agree_rnd", ov2, ov0);
            if (ov0) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_out_valid", ov0, 0);
                end else begin
                    mon_e = sbq.pop_front();
                    chk("latency_cycle", cyc, mon_e.due);
                    check_inst(0, "full", y0, s0, mon_e.acc, 0, 19);
                    check_inst(1, "sat12", y1, s1, mon_e.acc, 0, 12);
                    check_inst(2, "rnd12", y2, s2, mon_e.acc, 8, 12);
                end
            end else begin
                if (sbq.size() > 0 && sbq[0].due <= cyc) begin
                    void'(sbq.pop_front());
                    chk("missing_out_valid", ov0, 1);
                end
                hold_inst(0, "full", y0, s0);
                hold_inst(1, "sat12", y1, s1);
                hold_inst(2, "rnd12", y2, s2);
            end
        end
    end

    task automatic drive(bit iv, int x, bit clr = 1'b0, bit we = 1'b0, int a = 0, int d = 0);
        in_valid  = iv;
        xin       = 8'(x);
        clear     = clr;
        coef_we   = we;
        coef_addr = 3'(a);
        coef_data = 8'(d);
        @(negedge clk);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) drive(1'b0, 0);
    endtask

    initial begin
        int pat[7];
        pat = '{1, 0, 0, 1, 1, 0, 1};

        repeat (2) @(negedge clk);
        chk("rst_y", y0, 0);
        chk("rst_valid", ov0, 0);
        chk("rst_sat", s1, 0);
        rst = 1'b1;
        @(negedge clk);

        // Reset coefficients: moving sum of 3s ramps to 24.
        for (int i = 0; i < 12; i++) drive(1'b1, 3);
        chk("t1_steady_y", y0, 24);
        idle(3);

        // Four-tap ramp kernel, impulse from an emptied line.
        for (int k = 0; k < TAPS; k++) drive(1'b0, 0, 1'b0, 1'b1, k, (k < 4) ? k + 1 : 0);
        drive(1'b0, 0, 1'b1);
        drive(1'b1, 10);
        for (int i = 0; i < 10; i++) drive(1'b1, 0);
        idle(3);

        // Full-scale input with all coefficients at 255.
        for (int k = 0; k < TAPS; k++) drive(1'b0, 0, 1'b0, 1'b1, k, 255);
        for (int i = 0; i < 12; i++) drive(1'b1, 255);
        chk("t3_full_y", y0, 520200);
        chk("t3_sat12_y", y1, 4095);
        chk("t3_sat12_flag", s1, 1);
        chk("t3_rnd12_y", y2, 2032);
        chk("t3_rnd12_flag", s2, 0);
        idle(3);

        // Gapped valid pattern.
        for (int i = 0; i < 7; i++) drive(pat[i] != 0, $urandom_range(0, 255));
        idle(3);

        // Clear mid-stream with a coefficient write on the same edge.
        for (int i = 0; i < 5; i++) drive(1'b1, $urandom_range(0, 255));
        drive(1'b1, 77, 1'b1, 1'b1, 2, 9);
        for (int i = 0; i < 6; i++) drive(1'b1, $urandom_range(0, 255));
        idle(3);

        // Asynchronous reset between clock edges.
        for (int i = 0; i < 4; i++) drive(1'b1, $urandom_range(0, 255));
        in_valid = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("t6_async_y", y0, 0);
        chk("t6_async_valid", ov0, 0);
        chk("t6_async_rnd_y", y2, 0);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 12; i++) drive(1'b1, 3);
        chk("t6_coef_default_y", y0, 24);
        idle(3);

        // Randomised traffic with coefficient writes and occasional clears.
        for (int i = 0; i < 1500; i++) begin
            drive($urandom_range(0, 3) != 0,
                  $urandom_range(0, 255),
                  $urandom_range(0, 49) == 0,
                  $urandom_range(0, 9) == 0,
                  $urandom_range(0, 7),
                  ($urandom_range(0, 1) != 0) ? $urandom_range(0, 7) : $urandom_range(0, 255));
        end
        idle(5);
        chk("scoreboard_empty", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
